// File: rtl/riscv_crypto_fu_colseq_if.sv
// Bundles the request/response channel and the functional-unit operand bus of the
// column sequencer into one interface, so the sequencer and its environment share one port.
interface riscv_crypto_fu_colseq_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_acc;
   logic [31:0] req_src;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic [31:0] fu_rs1;
   logic [31:0] fu_rs2;
   logic [19:0] fu_instruction;
   logic [31:0] fu_rd;

   // The master side is the environment: the issue stage plus the combinational FU.
   modport master (
      output req_valid, req_op, req_acc, req_src, rsp_ready, fu_rd,
      input  req_ready, rsp_valid, rsp_data, rsp_err, fu_rs1, fu_rs2, fu_instruction
   );

   modport slave (
      input  req_valid, req_op, req_acc, req_src, rsp_ready, fu_rd,
      output req_ready, rsp_valid, rsp_data, rsp_err, fu_rs1, fu_rs2, fu_instruction
   );
endinterface

// File: rtl/riscv_crypto_fu_colseq.sv
// Sequences the combinational crypto FU through byte selects 0..3 so that one request
// yields a complete 32-bit AES or SM4 column transform, returned on a valid/ready channel.
module riscv_crypto_fu_colseq (
   input logic                     clk_i,
   input logic                     rst_i,
   riscv_crypto_fu_colseq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   state_e      state_q;
   logic [31:0] acc_q;
   logic [31:0] src_q;
   logic [2:0]  op_q;
   logic [1:0]  cnt_q;
   logic        err_q;
   logic        reqReady_q;
   logic        rspValid_q;

   logic [17:0] opOneHot;
   logic        running;
   logic        reqLegal;

   assign reqLegal = (bus.req_op <= 3'd5);
   assign running  = (state_q == RUN);

   // FU op-select bits: AES variants occupy 17..14, SM4 ks/ed occupy 1..0.
   always_comb begin
      opOneHot = '0;
      case (op_q)
         3'd0:    opOneHot[17] = 1'b1;
         3'd1:    opOneHot[16] = 1'b1;
         3'd2:    opOneHot[15] = 1'b1;
         3'd3:    opOneHot[14] = 1'b1;
         3'd4:    opOneHot[1]  = 1'b1;
         3'd5:    opOneHot[0]  = 1'b1;
         default: opOneHot     = '0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         src_q      <= '0;
         op_q       <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         reqReady_q <= 1'b1;
         rspValid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  acc_q      <= bus.req_acc;
                  src_q      <= bus.req_src;
                  op_q       <= bus.req_op;
                  cnt_q      <= 2'd0;
                  reqReady_q <= 1'b0;
                  if (reqLegal) begin
                     err_q   <= 1'b0;
                     state_q <= RUN;
                  end else begin
                     // Illegal ops skip the FU entirely and echo the accumulator back.
                     err_q      <= 1'b1;
                     rspValid_q <= 1'b1;
                     state_q    <= DONE;
                  end
               end
            end
            RUN: begin
               acc_q <= bus.fu_rd;
               cnt_q <= cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  rspValid_q <= 1'b1;
                  state_q    <= DONE;
               end
            end
            DONE: begin
               if (bus.rsp_ready) begin
                  rspValid_q <= 1'b0;
                  reqReady_q <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               rspValid_q <= 1'b0;
               reqReady_q <= 1'b1;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready      = reqReady_q;
   assign bus.rsp_valid      = rspValid_q;
   assign bus.rsp_data       = acc_q;
   assign bus.rsp_err        = err_q;
   // Outside RUN the FU operands are forced to zero so the unit idles and returns zero.
   assign bus.fu_rs1         = running ? acc_q : 32'h0;
   assign bus.fu_rs2         = running ? src_q : 32'h0;
   assign bus.fu_instruction = running ? {cnt_q, opOneHot} : 20'h0;

endmodule

// File: tb/tb_riscv_crypto_fu_colseq.sv
// Testbench for the column sequencer: a behavioural crypto FU closes the loop, and a
// request-level model predicts every output cycle by cycle from the accepted requests.
module tb_riscv_crypto_fu_colseq;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   riscv_crypto_fu_colseq_if bus ();

   riscv_crypto_fu_colseq dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int compared   = 0;
   int mismatched = 0;

   logic [7:0]    aesS [0:255];
   logic [7:0]    aesI [0:255];
   logic [2047:0] sm4Tab;

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      logic       hi;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         hi = x[7];
         x  = x << 1;
         if (hi) x = x ^ 8'h1b;
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(logic [7:0] x, int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [31:0] rol32(logic [31:0] x, int n);
      if ((n % 32) == 0) return x;
      return (x << (n % 32)) | (x >> (32 - (n % 32)));
   endfunction

   function automatic logic [7:0] sm4Box(logic [7:0] x);
      int idx;
      idx = (255 - int'(x)) * 8;
      return sm4Tab[idx +: 8];
   endfunction

   // Per-byte contribution f(x) of each instruction, before its byte-select rotation.
   function automatic logic [31:0] columnTerm(logic [2:0] op, logic [7:0] x);
      logic [7:0]  s;
      logic [31:0] w;
      logic [31:0] r;
      r = 32'h0;
      case (op)
         3'd0: r = {24'h0, aesS[x]};
         3'd1: begin
            s = aesS[x];
            r = {gmul(s, 8'h03), s, s, gmul(s, 8'h02)};
         end
         3'd2: r = {24'h0, aesI[x]};
         3'd3: begin
            s = aesI[x];
            r = {gmul(s, 8'h0b), gmul(s, 8'h0d), gmul(s, 8'h09), gmul(s, 8'h0e)};
         end
         3'd4: begin
            w = {24'h0, sm4Box(x)};
            r = w ^ ((w & 32'h07) << 29) ^ ((w & 32'hFE) << 7) ^ ((w & 32'h01) << 23) ^ ((w & 32'hF8) << 13);
         end
         3'd5: begin
            w = {24'h0, sm4Box(x)};
            r = w ^ (w << 8) ^ (w << 2) ^ (w << 18) ^ ((w & 32'h3F) << 26) ^ ((w & 32'hC0) << 10);
         end
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   // Closed-form column result after the first 'steps' byte positions have been folded in.
   function automatic logic [31:0] expectedAcc(logic [2:0] op, logic [31:0] acc, logic [31:0] src, int steps);
      logic [31:0] r;
      r = acc;
      for (int i = 0; i < steps; i++) r = r ^ rol32(columnTerm(op, src[8*i +: 8]), 8 * i);
      return r;
   endfunction

   function automatic logic [17:0] oneHotOf(logic [2:0] op);
      case (op)
         3'd0:    return 18'h20000;
         3'd1:    return 18'h10000;
         3'd2:    return 18'h08000;
         3'd3:    return 18'h04000;
         3'd4:    return 18'h00002;
         3'd5:    return 18'h00001;
         default: return 18'h00000;
      endcase
   endfunction

   initial begin
      logic [7:0] inv;
      logic [7:0] s;
      sm4Tab = {128'hD690E9FECCE13DB716B614C228FB2C05, 128'h2B679A762ABE04C3AA44132649860699,
                128'h9C4250F491EF987A33540B43EDCFAC62, 128'hE4B31CA9C908E89580DF94FA758F3FA6,
                128'h4707A7FCF37317BA83593C19E6854FA8, 128'h686B81B27164DA8BF8EB0F4B70569D35,
                128'h1E240E5E6358D1A225227C3B01217887, 128'hD40046579FD327524C3602E7A0C4C89E,
                128'hEABF8AD240C738B5A3F7F2CEF96115A1, 128'hE0AE5DA49B341A55AD933230F58CB1E3,
                128'h1DF6E22E8266CA60C02923AB0D534E6F, 128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
                128'h8D1BAF92BBDDBC7F11D95C411F105AD8, 128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
                128'h8969974A0C96777E65B9F109C56EC684, 128'h18F07DEC3ADC4D2079EE5F3ED7CB3948};
      for (int i = 0; i < 256; i++) begin
         inv = 8'h00;
         for (int j = 1; j < 256; j++) if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
         s = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
         aesS[i] = s;
         aesI[s] = 8'(i);
      end
   end

   // Behavioural FU: gated to zero when no op bit is set, otherwise rs1 ^ rol(f(byte), 8*bs).
   always_comb begin
      int          bs;
      logic [2:0]  fuOp;
      logic        fuHit;
      bs    = int'(bus.fu_instruction[19:18]);
      fuOp  = 3'd0;
      fuHit = 1'b1;
      if (bus.fu_instruction[17])      fuOp = 3'd0;
      else if (bus.fu_instruction[16]) fuOp = 3'd1;
      else if (bus.fu_instruction[15]) fuOp = 3'd2;
      else if (bus.fu_instruction[14]) fuOp = 3'd3;
      else if (bus.fu_instruction[1])  fuOp = 3'd4;
      else if (bus.fu_instruction[0])  fuOp = 3'd5;
      else                             fuHit = 1'b0;
      bus.fu_rd = 32'h0;
      if (fuHit) bus.fu_rd = bus.fu_rs1 ^ rol32(columnTerm(fuOp, bus.fu_rs2[8*bs +: 8]), 8 * bs);
   end

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Request-level model: mAge counts cycles since the accepting edge, -1 means no request held.
   bit          mValid = 1'b0;
   int          mAge   = -1;
   logic [2:0]  mOp;
   logic [31:0] mAcc;
   logic [31:0] mSrc;
   bit          mLegal;

   always @(posedge clk) begin
      if (rst) begin
         mValid <= 1'b1;
         mAge   <= -1;
      end else if (mValid) begin
         if (mAge < 0) begin
            if (bus.req_valid) begin
               mAge   <= 1;
               mOp    <= bus.req_op;
               mAcc   <= bus.req_acc;
               mSrc   <= bus.req_src;
               mLegal <= (bus.req_op < 3'd6);
            end
         end else if ((mLegal ? (mAge >= 5) : (mAge >= 1)) && bus.rsp_ready) begin
            mAge <= -1;
         end else begin
            mAge <= mAge + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (mValid) begin
         if (mAge < 0) begin
            checkOutput("idle_req_ready", bus.req_ready, 32'd1);
            checkOutput("idle_rsp_valid", bus.rsp_valid, 32'd0);
            checkOutput("idle_fu_instr", bus.fu_instruction, 32'd0);
            checkOutput("idle_fu_rs1", bus.fu_rs1, 32'd0);
            checkOutput("idle_fu_rs2", bus.fu_rs2, 32'd0);
         end else if (mLegal && mAge <= 4) begin
            checkOutput("run_req_ready", bus.req_ready, 32'd0);
            checkOutput("run_rsp_valid", bus.rsp_valid, 32'd0);
            checkOutput("run_fu_instr", bus.fu_instruction, {12'h0, 2'(mAge - 1), oneHotOf(mOp)});
            checkOutput("run_fu_rs1", bus.fu_rs1, expectedAcc(mOp, mAcc, mSrc, mAge - 1));
            checkOutput("run_fu_rs2", bus.fu_rs2, mSrc);
         end else begin
            checkOutput("done_req_ready", bus.req_ready, 32'd0);
            checkOutput("done_rsp_valid", bus.rsp_valid, 32'd1);
            checkOutput("done_rsp_data", bus.rsp_data, mLegal ? expectedAcc(mOp, mAcc, mSrc, 4) : mAcc);
            checkOutput("done_rsp_err", bus.rsp_err, mLegal ? 32'd0 : 32'd1);
            checkOutput("done_fu_instr", bus.fu_instruction, 32'd0);
         end
      end
   end

   // Drives a request from just after a rising edge and returns just after its accepting edge.
   task automatic applyStimulus(logic [2:0] op, logic [31:0] acc, logic [31:0] src);
      bit accepted;
      accepted      = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_acc   = acc;
      bus.req_src   = src;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            accepted = 1'b1;
            break;
         end
      end
      checkOutput("req_accepted", 32'(accepted), 32'd1);
      if (accepted) begin
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic waitResponse(string name, logic [31:0] expData, logic expErr, int expLat, bit checkSeq);
      int         lat;
      logic [7:0] bsSeq;
      lat   = 0;
      bsSeq = 8'h00;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.rsp_valid) begin
            lat = i;
            break;
         end
         bsSeq = {bus.fu_instruction[19:18], bsSeq[7:2]};
      end
      checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
      checkOutput({name, "_data"}, bus.rsp_data, expData);
      checkOutput({name, "_err"}, 32'(bus.rsp_err), 32'(expErr));
      checkOutput({name, "_fu_instr"}, bus.fu_instruction, 32'd0);
      if (checkSeq) checkOutput({name, "_bs_seq"}, 32'(bsSeq), 32'hE4);
      if (bus.rsp_ready) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] expA;
      logic [31:0] expB;
      logic [31:0] a;
      logic [31:0] s;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.req_acc   = 32'h0;
      bus.req_src   = 32'h0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_rsp_data", bus.rsp_data, 32'h0);
      checkOutput("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
      checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
      checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("reset_fu_rs1", bus.fu_rs1, 32'h0);
      @(posedge clk);
      #1;

      applyStimulus(3'd0, 32'h00000000, 32'h00000000);
      waitResponse("encs_zero", 32'h63636363, 1'b0, 5, 1'b1);
      applyStimulus(3'd0, 32'hFFFFFFFF, 32'h00000001);
      waitResponse("encs_ones", 32'h9C9C9C83, 1'b0, 5, 1'b1);
      applyStimulus(3'd1, 32'h00000000, 32'h00000000);
      waitResponse("encsm_zero", 32'h63636363, 1'b0, 5, 1'b1);
      applyStimulus(3'd2, 32'h00000000, 32'h00000000);
      waitResponse("decs_zero", 32'h52525252, 1'b0, 5, 1'b1);
      applyStimulus(3'd3, 32'h00000000, 32'h00000000);
      waitResponse("decsm_zero", 32'h52525252, 1'b0, 5, 1'b1);
      applyStimulus(3'd4, 32'h00000000, 32'h00000000);
      waitResponse("sm4ks_zero", 32'h67676767, 1'b0, 5, 1'b1);
      applyStimulus(3'd5, 32'h00000000, 32'h00000000);
      waitResponse("sm4ed_zero", 32'h5B5B5B5B, 1'b0, 5, 1'b1);

      for (int k = 0; k < 6; k++) begin
         a = 32'hC0FFEE00 + 32'(k);
         s = 32'h1F2E3D4C ^ (32'(k) * 32'h01030507);
         applyStimulus(3'(k), a, s);
         waitResponse("model_op", expectedAcc(3'(k), a, s, 4), 1'b0, 5, 1'b1);
      end

      applyStimulus(3'd7, 32'h12345678, 32'hFFFF0000);
      waitResponse("illegal7", 32'h12345678, 1'b1, 1, 1'b0);
      applyStimulus(3'd6, 32'hCAFEBABE, 32'h00000000);
      waitResponse("illegal6", 32'hCAFEBABE, 1'b1, 1, 1'b0);

      // Backpressure: hold the first response while a second request waits.
      bus.rsp_ready = 1'b0;
      expA = expectedAcc(3'd0, 32'hA5A5A5A5, 32'h3C3C0F0F, 4);
      expB = expectedAcc(3'd5, 32'h0BADF00D, 32'h89ABCDEF, 4);
      applyStimulus(3'd0, 32'hA5A5A5A5, 32'h3C3C0F0F);
      waitResponse("bp_first", expA, 1'b0, 5, 1'b1);
      fork
         applyStimulus(3'd5, 32'h0BADF00D, 32'h89ABCDEF);
         begin
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               checkOutput("bp_hold_data", bus.rsp_data, expA);
               checkOutput("bp_hold_ready", 32'(bus.req_ready), 32'd0);
            end
            @(posedge clk);
            #1 bus.rsp_ready = 1'b1;
         end
      join
      waitResponse("bp_second", expB, 1'b0, 5, 1'b1);

      // Reset in the middle of a run drops the request without a response.
      applyStimulus(3'd1, 32'h11223344, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      checkOutput("pre_rst_bs", 32'(bus.fu_instruction[19:18]), 32'd2);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("post_rst_fu_instr", bus.fu_instruction, 32'd0);
      checkOutput("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      applyStimulus(3'd1, 32'h11223344, 32'hDEADBEEF);
      waitResponse("post_rst_req", expectedAcc(3'd1, 32'h11223344, 32'hDEADBEEF, 4), 1'b0, 5, 1'b1);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
